// File: rtl/stim_gen_pkg.sv
// Shared types and constants for the stim_gen burst stimulus generator.
package stim_gen_pkg;

  typedef enum logic [1:0] {
    MODE_INCR  = 2'd0,
    MODE_CONST = 2'd1,
    MODE_LFSR  = 2'd2,
    MODE_WALK  = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_LFSR_POLY = 32'h80200003;

endpackage

// File: rtl/stim_lfsr.sv
// Combinational next-state of a Galois LFSR: shift right, fold POLY in when the dropped bit is 1.
module stim_lfsr
  import stim_gen_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(DEFAULT_LFSR_POLY)
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  assign o_next = (i_state >> 1) ^ (i_state[0] ? POLY : '0);

endmodule

// File: rtl/stim_gen.sv
// Burst stimulus source: addr/data stream with valid/ready, wrap window, selectable data pattern,
// last-beat marking, done/aborted completion pulse.
module stim_gen
  import stim_gen_pkg::*;
#(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    LEN_WIDTH  = 16,
  parameter logic [DATA_WIDTH-1:0] LFSR_POLY  = DATA_WIDTH'(DEFAULT_LFSR_POLY)
) (
  input  logic                  clk_100m,
  input  logic                  sys_rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [1:0]            cfg_mode,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [DATA_WIDTH-1:0] cfg_seed,
  input  logic [ADDR_WIDTH-1:0] cfg_addr_base,
  input  logic [ADDR_WIDTH-1:0] cfg_addr_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  aborted,
  output logic [LEN_WIDTH-1:0]  beat_cnt
);

  state_e                r_state;
  mode_e                 r_mode;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [ADDR_WIDTH-1:0] r_addr_base;
  logic [ADDR_WIDTH-1:0] r_addr_last;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_last;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_aborted;
  logic                  r_stop_pend;
  logic [LEN_WIDTH-1:0]  r_beat_cnt;

  logic                  w_hs;
  logic                  w_stop_any;
  logic [LEN_WIDTH-1:0]  w_next_cnt;
  logic [ADDR_WIDTH-1:0] w_addr_next;
  logic [DATA_WIDTH-1:0] w_data_next;
  logic [DATA_WIDTH-1:0] w_lfsr_next;
  logic [DATA_WIDTH-1:0] w_seed_fix;

  stim_lfsr #(
    .WIDTH (DATA_WIDTH),
    .POLY  (LFSR_POLY)
  ) u_lfsr (
    .i_state (r_data),
    .o_next  (w_lfsr_next)
  );

  assign w_hs        = r_valid && out_ready;
  assign w_stop_any  = r_stop_pend || stop;
  assign w_next_cnt  = r_beat_cnt + LEN_WIDTH'(1);
  assign w_addr_next = (r_addr == r_addr_last) ? r_addr_base : r_addr + ADDR_WIDTH'(1);

  // A zero seed would lock LFSR and WALK at zero forever, so those modes start from 1 instead.
  assign w_seed_fix = ((mode_e'(cfg_mode) == MODE_LFSR || mode_e'(cfg_mode) == MODE_WALK)
                       && cfg_seed == '0) ? DATA_WIDTH'(1) : cfg_seed;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_data_next = r_data;
    case (r_mode)
      MODE_INCR:  w_data_next = r_data + DATA_WIDTH'(1);
      MODE_CONST: w_data_next = r_data;
      MODE_LFSR:  w_data_next = w_lfsr_next;
      MODE_WALK:  w_data_next = {r_data[DATA_WIDTH-2:0], r_data[DATA_WIDTH-1]};
      default:    w_data_next = r_data;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_100m) begin
    if (sys_rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_INCR;
      r_len       <= '0;
      r_addr_base <= '0;
      r_addr_last <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      r_stop_pend <= 1'b0;
      r_beat_cnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && cfg_len != '0) begin
            r_mode      <= mode_e'(cfg_mode);
            r_len       <= cfg_len;
            r_addr_base <= cfg_addr_base;
            r_addr_last <= cfg_addr_last;
            r_addr      <= cfg_addr_base;
            r_data      <= w_seed_fix;
            r_valid     <= 1'b1;
            r_last      <= (cfg_len == LEN_WIDTH'(1));
            r_busy      <= 1'b1;
            r_stop_pend <= 1'b0;
            r_beat_cnt  <= '0;
            r_state     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_hs) begin
            r_beat_cnt <= w_next_cnt;
            if (r_last || w_stop_any) begin
              // A stop landing on the length-final beat still counts as a normal completion.
              r_valid     <= 1'b0;
              r_last      <= 1'b0;
              r_done      <= 1'b1;
              r_aborted   <= w_stop_any && !r_last;
              r_stop_pend <= 1'b0;
              r_state     <= ST_DONE;
            end else begin
              r_addr <= w_addr_next;
              r_data <= w_data_next;
              r_last <= (w_next_cnt == r_len - LEN_WIDTH'(1));
            end
          end else if (stop) begin
            r_stop_pend <= 1'b1;
          end
        end
        ST_DONE: begin
          r_done    <= 1'b0;
          r_aborted <= 1'b0;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign out_valid = r_valid;
  assign out_addr  = r_addr;
  assign out_data  = r_data;
  assign out_last  = r_last;
  assign busy      = r_busy;
  assign done      = r_done;
  assign aborted   = r_aborted;
  assign beat_cnt  = r_beat_cnt;

endmodule

// File: tb/tb_stim_gen.sv
// Directed self-checking bench for stim_gen: expected beats are queued at stimulus time and
// popped by a negedge monitor on every handshake.
module tb_stim_gen;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        sys_rst;
  logic        start;
  logic        stop;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_len;
  logic [31:0] cfg_seed;
  logic [31:0] cfg_addr_base;
  logic [31:0] cfg_addr_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        aborted;
  logic [15:0] beat_cnt;

  int    checks   = 0;
  int    failures = 0;
  beat_t sb_q[$];

  logic  mon_stall_prev = 1'b0;
  beat_t mon_held;
  beat_t mon_exp;

  always #5 clk = ~clk;

  stim_gen dut (
    .clk_100m      (clk),
    .sys_rst       (sys_rst),
    .start         (start),
    .stop          (stop),
    .cfg_mode      (cfg_mode),
    .cfg_len       (cfg_len),
    .cfg_seed      (cfg_seed),
    .cfg_addr_base (cfg_addr_base),
    .cfg_addr_last (cfg_addr_last),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_addr      (out_addr),
    .out_data      (out_data),
    .out_last      (out_last),
    .busy          (busy),
    .done          (done),
    .aborted       (aborted),
    .beat_cnt      (beat_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_beat(input logic [31:0] a, input logic [31:0] d, input logic l);
    beat_t b;
    b.addr = a;
    b.data = d;
    b.last = l;
    sb_q.push_back(b);
  endtask

  // Drives a one-cycle start pulse; returns at the edge after it, where the first beat must be up.
  task automatic start_burst(input logic [1:0] mode, input logic [15:0] len, input logic [31:0] seed,
                             input logic [31:0] base, input logic [31:0] last, input logic with_stop);
    @(posedge clk); #1;
    cfg_mode      = mode;
    cfg_len       = len;
    cfg_seed      = seed;
    cfg_addr_base = base;
    cfg_addr_last = last;
    start         = 1'b1;
    stop          = with_stop;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
    check("first_valid", out_valid, 1);
    check("first_busy", busy, 1);
    check("first_addr", out_addr, base);
  endtask

  // ready_mode 0: ready held high; 1: ready follows 1,0,0 repeating.
  task automatic finish_burst(input string tag, input int ready_mode,
                              input logic exp_ab, input logic [15:0] exp_cnt);
    bit seen = 1'b0;
    for (int c = 0; c < 500; c++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk); #1;
      out_ready = (ready_mode == 0) ? 1'b1 : ((c % 3) == 0);
    end
    if (!seen) begin
      check({tag, "_done_timeout"}, 0, 1);
    end else begin
      check({tag, "_aborted"}, aborted, exp_ab);
      check({tag, "_beat_cnt"}, beat_cnt, exp_cnt);
      check({tag, "_valid_low"}, out_valid, 0);
      check({tag, "_sb_empty"}, sb_q.size(), 0);
      @(posedge clk); #1;
      check({tag, "_done_pulse"}, done, 0);
      check({tag, "_busy_low"}, busy, 0);
      check({tag, "_cnt_hold"}, beat_cnt, exp_cnt);
    end
    out_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (sys_rst) begin
      mon_stall_prev = 1'b0;
    end else begin
      if (mon_stall_prev) begin
        check("hold_valid", out_valid, 1);
        check("hold_addr", out_addr, mon_held.addr);
        check("hold_data", out_data, mon_held.data);
        check("hold_last", out_last, mon_held.last);
      end
      mon_stall_prev = out_valid && !out_ready;
      mon_held.addr  = out_addr;
      mon_held.data  = out_data;
      mon_held.last  = out_last;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", out_addr, 64'hDEAD_BEEF_DEAD_BEEF);
        end else begin
          mon_exp = sb_q.pop_front();
          check("beat_addr", out_addr, mon_exp.addr);
          check("beat_data", out_data, mon_exp.data);
          check("beat_last", out_last, mon_exp.last);
        end
      end
    end
  end

  initial begin
    bit saw_done;
    sys_rst       = 1'b1;
    start         = 1'b0;
    stop          = 1'b0;
    out_ready     = 1'b0;
    cfg_mode      = 2'd0;
    cfg_len       = '0;
    cfg_seed      = '0;
    cfg_addr_base = '0;
    cfg_addr_last = '0;
    repeat (3) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    check("rst_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cnt", beat_cnt, 0);

    // Zero-length start is ignored.
    @(posedge clk); #1;
    cfg_len = 16'd0;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("len0_valid", out_valid, 0);
    check("len0_busy", busy, 0);

    // Reset mid-burst after two accepted beats.
    push_beat(32'h0, 32'h0, 1'b0);
    push_beat(32'h1, 32'h1, 1'b0);
    start_burst(2'd0, 16'd10, 32'h0, 32'h0, 32'hFF, 1'b0);
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_cnt", beat_cnt, 2);
    out_ready = 1'b0;
    sys_rst   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    sys_rst = 1'b0;
    check("midrst_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_cnt", beat_cnt, 0);
    check("midrst_sb_empty", sb_q.size(), 0);
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      saw_done = saw_done | done;
    end
    check("midrst_no_done", saw_done, 0);

    // INCR, ready held high.
    for (int i = 0; i < 4; i++) push_beat(32'h10 + i, 32'h100 + i, i == 3);
    out_ready = 1'b1;
    start_burst(2'd0, 16'd4, 32'h100, 32'h10, 32'hFF, 1'b0);
    finish_burst("incr", 0, 1'b0, 16'd4);

    // Same burst, ready stalling.
    for (int i = 0; i < 4; i++) push_beat(32'h10 + i, 32'h100 + i, i == 3);
    out_ready = 1'b1;
    start_burst(2'd0, 16'd4, 32'h100, 32'h10, 32'hFF, 1'b0);
    finish_burst("incr_stall", 1, 1'b0, 16'd4);

    // CONST with a two-entry wrap window.
    push_beat(32'h10, 32'hA5, 1'b0);
    push_beat(32'h11, 32'hA5, 1'b0);
    push_beat(32'h10, 32'hA5, 1'b0);
    push_beat(32'h11, 32'hA5, 1'b0);
    push_beat(32'h10, 32'hA5, 1'b1);
    out_ready = 1'b1;
    start_burst(2'd1, 16'd5, 32'hA5, 32'h10, 32'h11, 1'b0);
    finish_burst("const_wrap", 0, 1'b0, 16'd5);

    // INCR data rollover; base above last so the address wraps through zero.
    push_beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    push_beat(32'h0000_0000, 32'h0000_0000, 1'b0);
    push_beat(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    out_ready = 1'b1;
    start_burst(2'd0, 16'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 1'b0);
    finish_burst("incr_roll", 0, 1'b0, 16'd3);

    // LFSR from seed 1.
    push_beat(32'h20, 32'h0000_0001, 1'b0);
    push_beat(32'h21, 32'h8020_0003, 1'b0);
    push_beat(32'h22, 32'hC030_0002, 1'b1);
    out_ready = 1'b1;
    start_burst(2'd2, 16'd3, 32'h1, 32'h20, 32'hFF, 1'b0);
    finish_burst("lfsr", 0, 1'b0, 16'd3);

    // LFSR seed 0 substitutes 1; stop alongside start in IDLE is ignored.
    push_beat(32'h0, 32'h0000_0001, 1'b0);
    push_beat(32'h1, 32'h8020_0003, 1'b1);
    out_ready = 1'b1;
    start_burst(2'd2, 16'd2, 32'h0, 32'h0, 32'hF, 1'b1);
    finish_burst("lfsr_seed0", 0, 1'b0, 16'd2);

    // WALK seed 0; stop on the length-final handshake is not an abort.
    push_beat(32'h30, 32'h1, 1'b0);
    push_beat(32'h31, 32'h2, 1'b0);
    push_beat(32'h32, 32'h4, 1'b1);
    out_ready = 1'b1;
    start_burst(2'd3, 16'd3, 32'h0, 32'h30, 32'h3F, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    stop = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    finish_burst("walk_stop_last", 0, 1'b0, 16'd3);

    // Abort: stop while stalled after 3 beats, one more beat is accepted.
    for (int i = 0; i < 4; i++) push_beat(32'h200 + i, 32'h7 + i, 1'b0);
    out_ready = 1'b1;
    start_burst(2'd0, 16'd100, 32'h7, 32'h200, 32'hFFFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("abort_pre_cnt", beat_cnt, 3);
    out_ready = 1'b0;
    stop      = 1'b1;
    @(posedge clk); #1;
    stop = 1'b0;
    check("abort_still_valid", out_valid, 1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    finish_burst("abort", 0, 1'b1, 16'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
